// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - funct3 encodings and MMIO offsets shared by the data-memory responder
// Purpose : constants for load/store width decoding and the MMIO register map.
// Ports   : none (package).
package rv_mem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte offsets inside the MMIO page (word aligned)
  localparam logic [7:0] MMIO_OFF_GPIO  = 8'h00;
  localparam logic [7:0] MMIO_OFF_CYCLO = 8'h04;
  localparam logic [7:0] MMIO_OFF_CYCHI = 8'h08;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - M-stage data-memory port between the core and the responder
// Purpose : bundles the M-stage store/load signals.
// Signals : MemWriteM (store strobe), InstrM (funct3), ALUResultM (byte address),
//           WriteDataM (right-aligned store data), ReadDataM (extended load data).
// Modports: master = core side, slave = memory responder side.
interface dmem_responder_if;

  logic        MemWriteM;
  logic [2:0]  InstrM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;

  modport master (
    output MemWriteM,
    output InstrM,
    output ALUResultM,
    output WriteDataM,
    input  ReadDataM
  );

  modport slave (
    input  MemWriteM,
    input  InstrM,
    input  ALUResultM,
    input  WriteDataM,
    output ReadDataM
  );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational byte-lane steering for stores and load extension
// Purpose : from funct3 and the low address bits, produce store byte-enables, replicated
//           store data and the misalign flag, and the sign/zero-extended load result.
// Ports   : i_funct3  funct3 of the access
//           i_addr    address bits [1:0]
//           i_wdata   right-aligned store data
//           i_rword   raw 32-bit word read from storage
//           o_be      byte enables (0 when the store is misaligned or not a store width)
//           o_wdata   store data replicated onto every candidate lane
//           o_misalign SH with addr[0]=1 or SW with addr[1:0]!=0
//           o_rdata   extended load data (0 for non-load funct3)
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: replicating the data lets the enables alone pick the lanes.
  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr[0];
        if (!i_addr[0]) begin
          o_be = i_addr[1] ? 4'b1100 : 4'b0011;
        end
      end
      F3_W: begin
        o_misalign = (i_addr != 2'b00);
        if (i_addr == 2'b00) begin
          o_be = 4'b1111;
        end
      end
      default: ;
    endcase
  end

  // Load side: LH ignores addr[0], LW ignores addr[1:0].
  assign w_byte = i_rword[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_rdata = 32'h0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_W:    o_rdata = i_rword;
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_HU:   o_rdata = {16'h0, w_half};
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data RAM with byte-lane stores, sticky misalign flag and optional MMIO page
// Purpose : M-stage data memory for the RV32I core. Combinational (async) reads,
//           masked writes on the rising clk edge, misaligned-store capture,
//           saturating committed-store counter.
// Optional: define DMEM_MMIO_EN to decode the page ALUResultM[31:8]==MMIO_BASE[31:8]
//           (GPIO register at +0x00, 64-bit cycle counter at +0x04/+0x08).
// Ports   : clk          core clock
//           reset        asynchronous active-high reset
//           bus          M-stage port (slave modport): MemWriteM, InstrM, ALUResultM,
//                        WriteDataM in; ReadDataM out
//           ErrClr       clears the sticky misalign flag
//           MisalignErr  sticky misaligned-store flag
//           MisalignAddr address of the first misaligned store since the last clear
//           StoreCount   committed RAM stores, saturating
//           GpioOut      MMIO output register (0 without DMEM_MMIO_EN)
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  input  logic              ErrClr,
  output logic              MisalignErr,
  output logic [31:0]       MisalignAddr,
  output logic [31:0]       StoreCount,
  output logic [31:0]       GpioOut
);

  logic [31:0]   r_mem [DEPTH];
  logic          r_err;
  logic [31:0]   r_err_addr;
  logic [31:0]   r_store_cnt;

  logic [AW-1:0] w_widx;
  logic [31:0]   w_ram_word;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_rep;
  logic          w_misalign;
  logic [31:0]   w_rdata;
  logic          w_mmio_sel;
  logic [31:0]   w_mmio_word;
  logic          w_mis_store;
  logic          w_ram_we;

  assign w_widx     = bus.ALUResultM[AW+1:2];
  assign w_ram_word = r_mem[w_widx];

`ifdef DMEM_MMIO_EN
  logic [31:0] r_gpio;
  logic [63:0] r_cycle;
  logic [7:0]  w_mmio_off;
  logic        w_gpio_we;

  assign w_mmio_sel = (bus.ALUResultM[31:8] == MMIO_BASE[31:8]);
  assign w_mmio_off = {bus.ALUResultM[7:2], 2'b00};
  assign w_gpio_we  = bus.MemWriteM & w_mmio_sel & (w_mmio_off == MMIO_OFF_GPIO);

  always_comb begin
    w_mmio_word = 32'h0;
    case (w_mmio_off)
      MMIO_OFF_GPIO:  w_mmio_word = r_gpio;
      MMIO_OFF_CYCLO: w_mmio_word = r_cycle[31:0];
      MMIO_OFF_CYCHI: w_mmio_word = r_cycle[63:32];
      default:        w_mmio_word = 32'h0;
    endcase
  end

  // GPIO honours the same byte enables (and misalign suppression) as RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gpio  <= 32'h0;
      r_cycle <= 64'h0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_gpio_we) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) begin
            r_gpio[8*i +: 8] <= w_wdata_rep[8*i +: 8];
          end
        end
      end
    end
  end

  assign GpioOut = r_gpio;
`else
  logic w_unused_addr;

  assign w_mmio_sel    = 1'b0;
  assign w_mmio_word   = 32'h0;
  assign GpioOut       = 32'h0;
  assign w_unused_addr = ^{bus.ALUResultM[31:AW+2], MMIO_BASE};
`endif

  assign w_rword = w_mmio_sel ? w_mmio_word : w_ram_word;

  dmem_lane_align u_lane_align (
    .i_funct3   (bus.InstrM),
    .i_addr     (bus.ALUResultM[1:0]),
    .i_wdata    (bus.WriteDataM),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_rep),
    .o_misalign (w_misalign),
    .o_rdata    (w_rdata)
  );

  assign bus.ReadDataM = w_rdata;

  // w_be is already zero for misaligned or non-store funct3, so it doubles as the commit term.
  assign w_mis_store = bus.MemWriteM & w_misalign;
  assign w_ram_we    = bus.MemWriteM & (|w_be) & ~w_mmio_sel;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_widx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
        end
      end
    end
  end

  // A misaligned store beats ErrClr; with ErrClr it counts as the first error again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
    end else if (w_mis_store) begin
      r_err <= 1'b1;
      if (!r_err || ErrClr) begin
        r_err_addr <= bus.ALUResultM;
      end
    end else if (ErrClr) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store_cnt <= 32'h0;
    end else if (w_ram_we && (r_store_cnt != 32'hFFFF_FFFF)) begin
      r_store_cnt <= r_store_cnt + 32'd1;
    end
  end

  assign MisalignErr  = r_err;
  assign MisalignAddr = r_err_addr;
  assign StoreCount   = r_store_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
  import rv_mem_pkg::*;

  localparam int          DEPTH     = 1024;
  localparam int          NBYTES    = DEPTH * 4;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        ErrClr;
  logic        MisalignErr;
  logic [31:0] MisalignAddr;
  logic [31:0] StoreCount;
  logic [31:0] GpioOut;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH     (DEPTH),
    .AW        (10),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .ErrClr       (ErrClr),
    .MisalignErr  (MisalignErr),
    .MisalignAddr (MisalignAddr),
    .StoreCount   (StoreCount),
    .GpioOut      (GpioOut)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: a flat byte array plus the three architectural registers.
  byte unsigned m_mem [NBYTES];
  logic         m_err;
  logic [31:0]  m_addr;
  logic [31:0]  m_cnt;

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a_in);
    int unsigned a, hb, wb;
    int v;
    a  = a_in % NBYTES;
    hb = a - (a % 2);
    wb = a - (a % 4);
    case (f3)
      3'd0: begin v = m_mem[a]; if (v >= 128) v -= 256; return v; end
      3'd4: return m_mem[a];
      3'd1: begin
        v = m_mem[hb] + 256 * m_mem[hb+1];
        if (v >= 32768) v -= 65536;
        return v;
      end
      3'd5: return m_mem[hb] + 256 * m_mem[hb+1];
      3'd2: return {m_mem[wb+3], m_mem[wb+2], m_mem[wb+1], m_mem[wb]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step(input logic we, input logic [2:0] f3, input logic [31:0] a_in,
                        input logic [31:0] d, input logic clr);
    int unsigned a;
    logic        misal;
    logic        is_mmio;
    a       = a_in % NBYTES;
    misal   = we && ((f3 == 3'd1 && a_in % 2 != 0) || (f3 == 3'd2 && a_in % 4 != 0));
    is_mmio = 1'b0;
`ifdef DMEM_MMIO_EN
    is_mmio = (a_in[31:8] == MMIO_BASE[31:8]);
`endif
    if (misal) begin
      if (!m_err || clr) m_addr = a_in;
      m_err = 1'b1;
    end else begin
      if (clr) m_err = 1'b0;
      if (we && !is_mmio && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) begin
        for (int k = 0; k < (1 << f3); k++) m_mem[a + k] = d[8*k +: 8];
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
  endtask

  // One bus cycle: drive at negedge, sample ReadDataM before the edge, then update the model.
  task automatic cyc(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic clr, output logic [31:0] rd);
    @(negedge clk);
    bus.MemWriteM  = we;
    bus.InstrM     = f3;
    bus.ALUResultM = a;
    bus.WriteDataM = d;
    ErrClr         = clr;
    #1 rd = bus.ReadDataM;
    @(posedge clk);
    #1;
    bus.MemWriteM = 1'b0;
    ErrClr        = 1'b0;
    m_step(we, f3, a, d, clr);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp;
  } vec_t;

  vec_t        tv [20];
  logic [31:0] rd;
  logic [31:0] exp_rd;

  initial begin
    bus.MemWriteM  = 1'b0;
    bus.InstrM     = 3'd0;
    bus.ALUResultM = 32'h0;
    bus.WriteDataM = 32'h0;
    ErrClr         = 1'b0;
    m_err          = 1'b0;
    m_addr         = 32'h0;
    m_cnt          = 32'h0;
    for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;

    tv[0]  = '{1'b1, F3_W,  32'h10,   32'h11223344, 1'b0, 32'h0};
    tv[1]  = '{1'b0, F3_W,  32'h10,   32'h0,        1'b1, 32'h11223344};
    tv[2]  = '{1'b0, F3_B,  32'h13,   32'h0,        1'b1, 32'h00000011};
    tv[3]  = '{1'b0, F3_BU, 32'h10,   32'h0,        1'b1, 32'h00000044};
    tv[4]  = '{1'b1, F3_W,  32'h20,   32'hFFFFFFFF, 1'b0, 32'h0};
    tv[5]  = '{1'b1, F3_B,  32'h21,   32'hABCDEF80, 1'b0, 32'h0};
    tv[6]  = '{1'b0, F3_B,  32'h21,   32'h0,        1'b1, 32'hFFFFFF80};
    tv[7]  = '{1'b0, F3_W,  32'h20,   32'h0,        1'b1, 32'hFFFF80FF};
    tv[8]  = '{1'b0, F3_HU, 32'h22,   32'h0,        1'b1, 32'h0000FFFF};
    tv[9]  = '{1'b0, F3_H,  32'h12,   32'h0,        1'b1, 32'h00001122};
    tv[10] = '{1'b0, F3_H,  32'h20,   32'h0,        1'b1, 32'hFFFF80FF};
    tv[11] = '{1'b1, F3_H,  32'h12,   32'h1234BEEF, 1'b0, 32'h0};
    tv[12] = '{1'b0, F3_W,  32'h10,   32'h0,        1'b1, 32'hBEEF3344};
    tv[13] = '{1'b0, F3_HU, 32'h13,   32'h0,        1'b1, 32'h0000BEEF};
    tv[14] = '{1'b0, F3_BU, 32'h21,   32'h0,        1'b1, 32'h00000080};
    tv[15] = '{1'b0, 3'd3,  32'h10,   32'h0,        1'b1, 32'h00000000};
    tv[16] = '{1'b0, 3'd6,  32'h10,   32'h0,        1'b1, 32'h00000000};
    tv[17] = '{1'b1, F3_W,  32'h1008, 32'hA5A5A5A5, 1'b0, 32'h0};
    tv[18] = '{1'b0, F3_W,  32'h8,    32'h0,        1'b1, 32'hA5A5A5A5};
    tv[19] = '{1'b0, F3_W,  32'h1010, 32'h0,        1'b1, 32'hBEEF3344};

    // Reset state
    reset = 1'b1;
    #1;
    chk("reset_err",   {31'h0, MisalignErr}, 32'h0);
    chk("reset_maddr", MisalignAddr, 32'h0);
    chk("reset_count", StoreCount, 32'h0);
    chk("reset_gpio",  GpioOut, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      cyc(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, 1'b0, rd);
      if (tv[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, tv[i].exp);
    end
    chk("table_count", StoreCount, 32'd5);

    // Reserved funct3 store: no write, no count, no flag
    cyc(1'b1, 3'd3, 32'h10, 32'hDEADDEAD, 1'b0, rd);
    chk("f3_011_count", StoreCount, 32'd5);
    chk("f3_011_err", {31'h0, MisalignErr}, 32'h0);
    cyc(1'b0, F3_W, 32'h10, 32'h0, 1'b0, rd);
    chk("f3_011_nowrite", rd, 32'hBEEF3344);

    // Misaligned stores and the sticky flag
    cyc(1'b1, F3_W, 32'h30, 32'h01020304, 1'b0, rd);
    cyc(1'b1, F3_H, 32'h31, 32'h0000FFFF, 1'b0, rd);
    chk("mis_sh_err",   {31'h0, MisalignErr}, 32'h1);
    chk("mis_sh_addr",  MisalignAddr, 32'h31);
    chk("mis_sh_count", StoreCount, 32'd6);
    cyc(1'b0, F3_W, 32'h30, 32'h0, 1'b0, rd);
    chk("mis_sh_nowrite", rd, 32'h01020304);
    cyc(1'b1, F3_W, 32'h40, 32'h00000000, 1'b0, rd);
    cyc(1'b1, F3_W, 32'h42, 32'hFFFFFFFF, 1'b0, rd);
    chk("mis_sw_first_wins", MisalignAddr, 32'h31);
    chk("mis_sw_count", StoreCount, 32'd7);
    cyc(1'b0, F3_W, 32'h40, 32'h0, 1'b0, rd);
    chk("mis_sw_nowrite", rd, 32'h00000000);
    cyc(1'b1, F3_W, 32'h46, 32'h12345678, 1'b1, rd);
    chk("clr_set_wins_err",  {31'h0, MisalignErr}, 32'h1);
    chk("clr_set_wins_addr", MisalignAddr, 32'h46);
    cyc(1'b0, F3_W, 32'h0, 32'h0, 1'b1, rd);
    chk("clr_err", {31'h0, MisalignErr}, 32'h0);
    cyc(1'b1, F3_H, 32'h51, 32'h0, 1'b0, rd);
    chk("mis_after_clr_addr", MisalignAddr, 32'h51);

    // Read during write returns old data, new data next cycle
    cyc(1'b1, F3_W, 32'h60, 32'h0BADF00D, 1'b0, rd);
    cyc(1'b1, F3_W, 32'h60, 32'h600DCAFE, 1'b0, rd);
    chk("rdw_old", rd, 32'h0BADF00D);
    cyc(1'b0, F3_W, 32'h60, 32'h0, 1'b0, rd);
    chk("rdw_new", rd, 32'h600DCAFE);
    chk("gpio_idle", GpioOut, 32'h0);

    // Randomized traffic against the model
    for (int w = 0; w < 16; w++) cyc(1'b1, F3_W, 32'h400 + 4 * w, $urandom, 1'b0, rd);
    for (int n = 0; n < 300; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_a;
      logic [31:0] r_d;
      logic        r_clr;
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_a    = ($urandom & 32'h7FFF_F000) | 32'h400 | 32'($urandom_range(0, 63));
      r_d    = $urandom;
      r_clr  = ($urandom_range(0, 15) == 0);
      exp_rd = m_load(r_f3, r_a);
      cyc(r_we, r_f3, r_a, r_d, r_clr, rd);
      chk($sformatf("rnd%0d_rd", n), rd, exp_rd);
      chk($sformatf("rnd%0d_err", n), {31'h0, MisalignErr}, {31'h0, m_err});
      chk($sformatf("rnd%0d_maddr", n), MisalignAddr, m_addr);
      chk($sformatf("rnd%0d_count", n), StoreCount, m_cnt);
    end

    // Asynchronous reset mid-run
    cyc(1'b1, F3_H, 32'h401, 32'h0, 1'b0, rd);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_err",   {31'h0, MisalignErr}, 32'h0);
    chk("async_rst_maddr", MisalignAddr, 32'h0);
    chk("async_rst_count", StoreCount, 32'h0);
    chk("async_rst_gpio",  GpioOut, 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    m_err  = 1'b0;
    m_addr = 32'h0;
    m_cnt  = 32'h0;
    exp_rd = m_load(F3_W, 32'h10);
    cyc(1'b0, F3_W, 32'h10, 32'h0, 1'b0, rd);
    chk("ram_kept_after_rst", rd, exp_rd);

`ifdef DMEM_MMIO_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    cyc(1'b0, F3_W, MMIO_BASE + 32'h4, 32'h0, 1'b0, rd);
    chk("mmio_cyclo", rd, 32'd7);
    cyc(1'b0, F3_W, MMIO_BASE + 32'h8, 32'h0, 1'b0, rd);
    chk("mmio_cychi", rd, 32'd0);
    cyc(1'b1, F3_W, 32'h0, 32'h12345678, 1'b0, rd);
    cyc(1'b1, F3_B, MMIO_BASE + 32'h1, 32'hFFFFFF5A, 1'b0, rd);
    chk("mmio_gpio_sb", GpioOut, 32'h00005A00);
    chk("mmio_no_count", StoreCount, 32'd1);
    cyc(1'b1, F3_W, MMIO_BASE + 32'h4, 32'hFFFFFFFF, 1'b0, rd);
    chk("mmio_gpio_keep", GpioOut, 32'h00005A00);
    cyc(1'b0, F3_W, MMIO_BASE, 32'h0, 1'b0, rd);
    chk("mmio_gpio_rd", rd, 32'h00005A00);
    cyc(1'b0, F3_BU, MMIO_BASE + 32'h1, 32'h0, 1'b0, rd);
    chk("mmio_gpio_lbu", rd, 32'h0000005A);
    cyc(1'b0, F3_W, MMIO_BASE + 32'hC, 32'h0, 1'b0, rd);
    chk("mmio_other_off", rd, 32'h0);
    cyc(1'b0, F3_W, 32'h0, 32'h0, 1'b0, rd);
    chk("mmio_ram_intact", rd, 32'h12345678);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
